// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Bus bundle between the VeriRisc controller (initiator) and the memory-side
// responder (target). The tri-state data bus is split into data_in/data_out
// with data_oe showing when the responder owns the bus.
//
// Signals:
//   addr     initiator -> target  access address
//   rd       initiator -> target  read request level, held until rdy
//   wr       initiator -> target  write request level
//   data_e   initiator -> target  initiator is driving data_in
//   data_in  initiator -> target  write data
//   data_out target -> initiator  read data, valid while data_oe=1
//   data_oe  target -> initiator  responder owns the data bus
//   rdy      target -> initiator  access complete
//   err      target -> initiator  one-cycle protocol-error pulse
//
// Modports: master (initiator side), slave (responder side).
// -----------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic          data_e;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          data_oe;
    logic          rdy;
    logic          err;

    modport master (
        output addr, rd, wr, data_e, data_in,
        input  data_out, data_oe, rdy, err
    );

    modport slave (
        input  addr, rd, wr, data_e, data_in,
        output data_out, data_oe, rdy, err
    );
endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side target for the VeriRisc controller's bus strobes. Holds a
// 2^AW x DW RAM and services single-beat reads and writes after WAIT_STATES
// extra cycles, signalling completion on rdy.
//
// Parameters:
//   AW           address width (depth = 2^AW)
//   DW           data width
//   WAIT_STATES  extra cycles before a read is driven / a write commits (0..15)
//
// Ports:
//   clk  clock, all logic on posedge
//   rst  synchronous, active-high reset (RAM contents are kept)
//   bus  mem_responder_if.slave: addr, rd, wr, data_e, data_in (in),
//        data_out, data_oe, rdy, err (out)
//
// Optional build macro:
//   WR_PROTECT_EN  makes addresses 0 .. 2^(AW-2)-1 read-only. Writes there
//                  still complete normally with rdy, leave the RAM untouched
//                  and pulse err together with rdy.
//
// Outputs are registered and decoded from the next state, so rdy/data_oe
// rise on the same edge that the FSM enters RD_DRIVE or WR_DONE.
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int AW          = 5,
    parameter int DW          = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_DRIVE = 3'd2,
        WR_WAIT  = 3'd3,
        WR_DONE  = 3'd4,
        WR_HOLD  = 3'd5
    } state_t;

    localparam int DEPTH = 1 << AW;

    // With no wait states a request goes straight to its completion state.
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    // Counter preload: the wait state that sees counter=0 is the last one.
    localparam logic [3:0] WS_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

`ifdef WR_PROTECT_EN
    // Read-only region is the lowest quarter of the address space.
    function automatic logic is_protected(input logic [AW-1:0] a);
        return (a[AW-1 -: 2] == 2'b00);
    endfunction
`endif

    state_t        state_r;
    state_t        state_next_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_next_s;
    logic [AW-1:0] addr_q_r;
    logic [AW-1:0] addr_q_next_s;
    logic [DW-1:0] data_q_r;
    logic [DW-1:0] data_q_next_s;

    logic          commit_s;
    logic [AW-1:0] commit_addr_s;
    logic [DW-1:0] commit_data_s;
    logic          commit_blocked_s;
    logic          mem_we_s;
    logic          proto_err_s;
    logic          err_next_s;
    logic [AW-1:0] rd_addr_s;

    logic [DW-1:0] data_out_r;
    logic          data_oe_r;
    logic          rdy_r;
    logic          err_r;

    logic [DW-1:0] mem_r [DEPTH];

    // Next-state, latch-update and RAM-commit decode.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        addr_q_next_s = addr_q_r;
        data_q_next_s = data_q_r;
        commit_s      = 1'b0;
        commit_addr_s = addr_q_r;
        commit_data_s = data_q_r;
        proto_err_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (bus.rd && bus.wr) begin
                    proto_err_s = 1'b1;
                end else if (bus.rd) begin
                    addr_q_next_s = bus.addr;
                    if (NO_WAIT) begin
                        state_next_s = RD_DRIVE;
                    end else begin
                        state_next_s = RD_WAIT;
                        cnt_next_s   = WS_INIT;
                    end
                end else if (bus.wr && bus.data_e) begin
                    addr_q_next_s = bus.addr;
                    data_q_next_s = bus.data_in;
                    if (NO_WAIT) begin
                        // Commit on the accepting edge straight from the bus.
                        state_next_s  = WR_DONE;
                        commit_s      = 1'b1;
                        commit_addr_s = bus.addr;
                        commit_data_s = bus.data_in;
                    end else begin
                        state_next_s = WR_WAIT;
                        cnt_next_s   = WS_INIT;
                    end
                end else begin
                    // A write without data_e is simply not accepted.
                    state_next_s = IDLE;
                end
            end

            RD_WAIT: begin
                if (!bus.rd) begin
                    state_next_s = IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_next_s = RD_DRIVE;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end

            RD_DRIVE: begin
                if (!bus.rd) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RD_DRIVE;
                end
            end

            WR_WAIT: begin
                if (!bus.wr) begin
                    state_next_s = IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_next_s = WR_DONE;
                    commit_s     = 1'b1;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end

            WR_DONE: begin
                if (bus.wr) begin
                    state_next_s = WR_HOLD;
                end else begin
                    state_next_s = IDLE;
                end
            end

            WR_HOLD: begin
                // Wait for wr to drop so one long strobe is one write.
                if (bus.wr) begin
                    state_next_s = WR_HOLD;
                end else begin
                    state_next_s = IDLE;
                end
            end

            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Write-protect qualification and error-pulse source.
    always_comb begin
`ifdef WR_PROTECT_EN
        commit_blocked_s = commit_s && is_protected(commit_addr_s);
`else
        commit_blocked_s = 1'b0;
`endif
        mem_we_s   = commit_s && !commit_blocked_s;
        err_next_s = proto_err_s || commit_blocked_s;
    end

    // Read address: from the bus on the accepting edge, from the latch after.
    always_comb begin
        if (state_r == IDLE) begin
            rd_addr_s = bus.addr;
        end else begin
            rd_addr_s = addr_q_r;
        end
    end

    // FSM state, wait counter, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            addr_q_r   <= {AW{1'b0}};
            data_q_r   <= {DW{1'b0}};
            data_out_r <= {DW{1'b0}};
            data_oe_r  <= 1'b0;
            rdy_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            addr_q_r  <= addr_q_next_s;
            data_q_r  <= data_q_next_s;
            data_oe_r <= (state_next_s == RD_DRIVE);
            rdy_r     <= (state_next_s == RD_DRIVE) || (state_next_s == WR_DONE);
            err_r     <= err_next_s;
            if (state_next_s == RD_DRIVE) begin
                data_out_r <= mem_r[rd_addr_s];
            end else begin
                data_out_r <= {DW{1'b0}};
            end
        end
    end

    // RAM write port; contents survive reset, but reset blocks a commit.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_r[commit_addr_s] <= commit_data_s;
        end
    end

    assign bus.data_out = data_out_r;
    assign bus.data_oe  = data_oe_r;
    assign bus.rdy      = rdy_r;
    assign bus.err      = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Two responders (WAIT_STATES=0 as dut 0, WAIT_STATES=3 as dut 1) driven by
// directed transactions. Each transaction pushes its expected response
// (dut, cycle, rdy, err, data_oe, data) into a queue; a monitor pops an entry
// whenever a dut raises rdy or err and compares it.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if #(.AW(5), .DW(8)) if0 ();
    mem_responder_if #(.AW(5), .DW(8)) if1 ();

    mem_responder #(.AW(5), .DW(8), .WAIT_STATES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    mem_responder #(.AW(5), .DW(8), .WAIT_STATES(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    logic [1:0] rd_v  = 2'b00;
    logic [1:0] wr_v  = 2'b00;
    logic [1:0] de_v  = 2'b00;
    logic [4:0] addr_v [2];
    logic [7:0] din_v  [2];

    assign if0.rd      = rd_v[0];
    assign if0.wr      = wr_v[0];
    assign if0.data_e  = de_v[0];
    assign if0.addr    = addr_v[0];
    assign if0.data_in = din_v[0];
    assign if1.rd      = rd_v[1];
    assign if1.wr      = wr_v[1];
    assign if1.data_e  = de_v[1];
    assign if1.addr    = addr_v[1];
    assign if1.data_in = din_v[1];

    logic [1:0] rdy_w;
    logic [1:0] err_w;
    logic [1:0] oe_w;
    logic [7:0] dout_w [2];

    assign rdy_w     = {if1.rdy, if0.rdy};
    assign err_w     = {if1.err, if0.err};
    assign oe_w      = {if1.data_oe, if0.data_oe};
    assign dout_w[0] = if0.data_out;
    assign dout_w[1] = if1.data_out;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         dut;
        int         cyc;
        logic       rdy;
        logic       err;
        logic       oe;
        logic       chk;
        logic [7:0] data;
        string      name;
    } exp_t;

    exp_t exp_q [$];

    localparam int WS [2] = '{0, 3};

    function automatic void push_exp(input int d, input int c, input logic r,
                                     input logic e, input logic o, input logic k,
                                     input logic [7:0] v, input string nm);
        exp_t x;
        x.dut = d; x.cyc = c; x.rdy = r; x.err = e; x.oe = o; x.chk = k;
        x.data = v; x.name = nm;
        exp_q.push_back(x);
    endfunction

    // Monitor: every rising rdy or err is a response event to be matched.
    logic [1:0] rdy_p = 2'b00;
    logic [1:0] err_p = 2'b00;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if ((rdy_w[d] && !rdy_p[d]) || (err_w[d] && !err_p[d])) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event dut=%0d cyc=%0d rdy=%b err=%b oe=%b, required no event",
                             d, cyc, rdy_w[d], err_w[d], oe_w[d]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.dut != d || e.cyc != cyc || e.rdy != rdy_w[d] ||
                        e.err != err_w[d] || e.oe != oe_w[d] ||
                        (e.chk && (e.data != dout_w[d]))) begin
                        n_fail++;
                        $display("FAIL %s: got dut=%0d cyc=%0d rdy=%b err=%b oe=%b data=%h, required dut=%0d cyc=%0d rdy=%b err=%b oe=%b data=%h",
                                 e.name, d, cyc, rdy_w[d], err_w[d], oe_w[d], dout_w[d],
                                 e.dut, e.cyc, e.rdy, e.err, e.oe, e.data);
                    end
                end
            end
        end
        rdy_p <= rdy_w;
        err_p <= err_w;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    // Full write: returns at a negedge with the dut back in IDLE.
    task automatic do_write(input int d, input logic [4:0] a, input logic [7:0] v,
                            input logic e, input string nm);
        addr_v[d] = a; din_v[d] = v; wr_v[d] = 1'b1; de_v[d] = 1'b1;
        push_exp(d, cyc + 1 + WS[d], 1'b1, e, 1'b0, 1'b0, 8'h00, nm);
        repeat (WS[d] + 1) step();
        wr_v[d] = 1'b0; de_v[d] = 1'b0;
        step();
    endtask

    // Full read with rd held for hold cycles after rdy; address is scrambled
    // while driving to show the latched address is used.
    task automatic do_read(input int d, input logic [4:0] a, input logic [7:0] v,
                           input logic k, input int hold, input string nm,
                           output logic [7:0] got);
        addr_v[d] = a; rd_v[d] = 1'b1;
        push_exp(d, cyc + 1 + WS[d], 1'b1, 1'b0, 1'b1, k, v, nm);
        repeat (WS[d] + 1) step();
        got = dout_w[d];
        addr_v[d] = ~a;
        for (int i = 0; i < hold; i++) begin
            step();
            check({nm, "_hold_oe"}, {7'h00, oe_w[d]}, 8'h01);
            check({nm, "_hold_rdy"}, {7'h00, rdy_w[d]}, 8'h01);
            if (k) check({nm, "_hold_data"}, dout_w[d], v);
        end
        rd_v[d] = 1'b0;
        step();
        check({nm, "_release_oe"}, {7'h00, oe_w[d]}, 8'h00);
        check({nm, "_release_rdy"}, {7'h00, rdy_w[d]}, 8'h00);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] old03;
        int c0;

        addr_v[0] = 5'h00; addr_v[1] = 5'h00;
        din_v[0]  = 8'h00; din_v[1]  = 8'h00;

        // Reset held with rd high: outputs stay quiet.
        rd_v = 2'b11;
        for (int i = 0; i < 2; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                check("reset_oe",  {7'h00, oe_w[d]},  8'h00);
                check("reset_rdy", {7'h00, rdy_w[d]}, 8'h00);
                check("reset_err", {7'h00, err_w[d]}, 8'h00);
            end
        end
        rst = 1'b0;
        c0 = cyc;
        push_exp(0, c0 + 1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "post_reset_read_ws0");
        push_exp(1, c0 + 4, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "post_reset_read_ws3");
        repeat (4) step();
        rd_v = 2'b00;
        step();

        // No wait states: write then read back, back to back.
        do_write(0, 5'h0A, 8'h5C, 1'b0, "wr_0a_ws0");
        do_read(0, 5'h0A, 8'h5C, 1'b1, 2, "rd_0a_ws0", got);

        // Same access on both duts: ws3 latency is three cycles longer.
        do_write(0, 5'h1F, 8'hA7, 1'b0, "wr_1f_ws0");
        do_read(0, 5'h1F, 8'hA7, 1'b1, 1, "rd_1f_ws0", got);
        do_write(1, 5'h1F, 8'hA7, 1'b0, "wr_1f_ws3");
        do_read(1, 5'h1F, 8'hA7, 1'b1, 2, "rd_1f_ws3", got);

        // Aborted write after one wait cycle leaves the old value.
        do_write(1, 5'h10, 8'h42, 1'b0, "wr_10_ws3");
        addr_v[1] = 5'h10; din_v[1] = 8'hFF; wr_v[1] = 1'b1; de_v[1] = 1'b1;
        step();
        step();
        wr_v[1] = 1'b0; de_v[1] = 1'b0;
        repeat (6) step();
        do_read(1, 5'h10, 8'h42, 1'b1, 0, "rd_10_after_abort", got);

        // Aborted read: rd dropped during the wait gives no rdy.
        addr_v[1] = 5'h1F; rd_v[1] = 1'b1;
        step();
        step();
        rd_v[1] = 1'b0;
        repeat (5) step();

        // Write without data_e is ignored.
        addr_v[0] = 5'h0A; din_v[0] = 8'h99; wr_v[0] = 1'b1; de_v[0] = 1'b0;
        repeat (3) step();
        wr_v[0] = 1'b0;
        step();
        do_read(0, 5'h0A, 8'h5C, 1'b1, 0, "rd_0a_after_no_de", got);

        // Simultaneous rd/wr: one err pulse, no rdy, RAM unchanged.
        do_write(0, 5'h15, 8'h11, 1'b0, "wr_15");
        addr_v[0] = 5'h15; din_v[0] = 8'hEE;
        rd_v[0] = 1'b1; wr_v[0] = 1'b1; de_v[0] = 1'b1;
        push_exp(0, cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "rd_wr_collision");
        step();
        rd_v[0] = 1'b0; wr_v[0] = 1'b0; de_v[0] = 1'b0;
        step();
        check("collision_err_len", {7'h00, err_w[0]}, 8'h00);
        do_read(0, 5'h15, 8'h11, 1'b1, 0, "rd_15_after_collision", got);

        // wr held past WR_DONE: one write only, new bus values ignored.
        do_write(0, 5'h17, 8'h70, 1'b0, "wr_17");
        addr_v[0] = 5'h16; din_v[0] = 8'h66; wr_v[0] = 1'b1; de_v[0] = 1'b1;
        push_exp(0, cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "wr_16_held");
        step();
        addr_v[0] = 5'h17; din_v[0] = 8'h77;
        repeat (3) step();
        wr_v[0] = 1'b0; de_v[0] = 1'b0;
        step();
        do_read(0, 5'h16, 8'h66, 1'b1, 0, "rd_16_after_hold", got);
        do_read(0, 5'h17, 8'h70, 1'b1, 0, "rd_17_after_hold", got);

        // Write-protect boundary.
        do_write(0, 5'h08, 8'h9D, 1'b0, "wr_08");
        do_read(0, 5'h08, 8'h9D, 1'b1, 0, "rd_08", got);
`ifdef WR_PROTECT_EN
        do_read(0, 5'h03, 8'h00, 1'b0, 0, "rd_03_before", old03);
        do_write(0, 5'h03, 8'h33, 1'b1, "wr_03_protected");
        do_read(0, 5'h03, 8'h00, 1'b0, 0, "rd_03_after", got);
        check("protect_unchanged", got, old03);
`else
        old03 = 8'h00;
        do_write(0, 5'h03, 8'h33, 1'b0, "wr_03");
        do_read(0, 5'h03, 8'h33, 1'b1, 0, "rd_03", got);
        check("rd_03_got", got | old03, 8'h33);
`endif

        // Back-to-back on ws3: write then immediate read of same address.
        do_write(1, 5'h0A, 8'hC3, 1'b0, "wr_0a_ws3");
        do_read(1, 5'h0A, 8'hC3, 1'b1, 1, "rd_0a_ws3", got);

        repeat (10) step();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: %0d still pending, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
